edge_scan_ctrl: RTL
===================

# edge_scan_ctrl

Raster-scan sequencer for the Sobel-style edge detector. It walks every pixel of an IMG_W x IMG_H frame and requests a 3x3 window from the line buffer for each interior pixel. For each such pixel it fires the detector for one cycle, captures the edge bit when the detector's completion strobe arrives, and hands a per-pixel edge flag to the downstream stage over a valid/ready handshake. Border pixels bypass the detector and are reported as non-edge.

## Interface
- IMG_W, 640, frame width in pixels (>= 3)
- IMG_H, 480, frame height in pixels (>= 3)
- TMO, 4, cycles after the fire cycle to wait for mean_average_enable before declaring a timeout (>= 3)
- clk  in  1  clock, all logic on rising edge
- n_rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a frame when idle, ignored when busy
- abort  in  1  synchronous abort; returns to IDLE next cycle
- threshold_in  in  8  edge threshold, latched on accepted start
- grid_valid  in  1  line buffer holds the window centred at (cur_x, cur_y)
- mean_average_enable  in  1  detector completion strobe
- isEdge  in  1  detector edge result
- result_ready  in  1  downstream accepts result
- iThreshold  out  8  latched threshold to detector
- edgedetect_enable  out  1  detector fire, high exactly one cycle per interior pixel
- grid_req  out  1  one-cycle request for the window at (cur_x, cur_y)
- cur_x  out  clog2(IMG_W)  current pixel column
- cur_y  out  clog2(IMG_H)  current pixel row
- result_valid  out  1  result_edge/cur_x/cur_y valid
- result_edge  out  1  1 = edge pixel
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last pixel is accepted
- err  out  1  sticky timeout flag, cleared on accepted start or reset

## Operation
- States: IDLE, NEXT, GRID, FIRE, WAIT, OUT, DONE. All outputs are decoded from registered state or come from registers; there are no combinational input-to-output paths.
- IDLE: busy=0. When start=1, latch threshold_in into iThreshold, clear cur_x, cur_y and err, then go to NEXT.
- NEXT: a border pixel is one with cur_x==0, cur_x==IMG_W-1, cur_y==0 or cur_y==IMG_H-1.
  - Border pixel: set result_edge=0 and go to OUT.
  - Interior pixel: grid_req=1 for this cycle, then go to GRID.
- GRID: hold until grid_valid=1, then go to FIRE. There is no limit on the wait.
- FIRE: edgedetect_enable=1 for this cycle only. Clear the wait counter and go to WAIT.
- WAIT: increment the wait counter each cycle.
  - mean_average_enable=1: capture isEdge into result_edge and go to OUT.
  - Counter reaches TMO with no strobe: set err=1, set result_edge=0, and go to OUT.
- OUT: result_valid=1, with result_edge, cur_x and cur_y held stable. On result_ready=1, advance the coordinates:
  - cur_x increments.
  - At IMG_W-1, cur_x wraps to 0 and cur_y increments.
  - If the accepted pixel was (IMG_W-1, IMG_H-1), go to DONE; otherwise go to NEXT.
- DONE: done=1 for one cycle, then go to IDLE. cur_x and cur_y stay at their final values.
- The line buffer must hold the window stable from grid_valid until the next grid_req. The detector samples the window in the FIRE cycle and the following cycle.
- abort=1 in any state takes effect next cycle:
  - State goes to IDLE.
  - result_valid, edgedetect_enable, grid_req and busy are deasserted.
  - done does not pulse, and err is kept.
- A start that arrives during busy is ignored.
- If start and abort are high together in IDLE, abort wins and the block stays in IDLE.
- The strobe check has priority over the timeout: if mean_average_enable=1 in the same cycle the counter reaches TMO, the result is captured and err is not set.
- Reset values: state=IDLE, all 1-bit outputs 0, iThreshold=0, cur_x=0, cur_y=0, wait counter=0. A reset mid-frame discards the frame.

## Timing
- With the fire cycle at T, the detector raises mean_average_enable at T+2 and isEdge is captured at the end of T+2. result_valid rises at T+3.
- Interior pixel with grid_valid and result_ready already high: 6 cycles per pixel (NEXT, GRID, FIRE, WAIT, WAIT, OUT).
- Border pixel with result_ready high: 2 cycles (NEXT, OUT).
- start accepted at cycle C: busy=1 and state=NEXT from C+1.
- After the last pixel is accepted at cycle L: done=1 at L+1 and busy=0 from L+2.
- A timeout with no strobe asserts err at T+TMO and result_valid at T+TMO+1.

## Test plan
- IMG_W=4, IMG_H=3, result_ready=1, grid_valid=1, detector model with 2-cycle latency and isEdge=1 -> exactly 12 results in raster order. Only (1,1) and (2,1) have result_edge=1, there are exactly 2 edgedetect_enable pulses, done pulses once, and the total is 10x2+2x6 cycles from start to done.
- Same frame with result_ready low for 5 cycles on pixel (2,1) -> result_valid, result_edge and coordinates stay stable; the pixel is accepted once; no extra grid_req or edgedetect_enable.
- grid_valid held low for 7 cycles after grid_req at (1,1) -> edgedetect_enable does not fire until the cycle after grid_valid rises; the threshold_in=0x40 latched at start appears on iThreshold throughout.
- Detector model never strobes, TMO=4 -> err=1 at T+4; result_edge=0 for (1,1); the scan completes and err remains 1 until the next start.
- abort asserted in WAIT on pixel (2,1) -> IDLE next cycle, busy=0, no done. A new start rescans from (0,0) with err cleared.
- n_rst=0 for one cycle mid-frame, with start pulsed during busy beforehand -> all outputs reach their reset values next cycle. The start pulsed during busy had no effect.

Source files
------------

// File: rtl/edge_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : edge_scan_ctrl
//  Purpose  : Raster-scan sequencer for the Sobel-style edge detector. Walks
//             every pixel of an IMG_W x IMG_H frame. For each interior pixel it
//             requests a 3x3 window, fires the detector for one cycle and
//             captures the edge bit on the completion strobe. Border pixels are
//             reported as non-edge without touching the detector. Each pixel
//             result leaves over a valid/ready handshake.
//  Ports    : clk, n_rst (sync, active-low)
//             start / abort                      - frame control
//             threshold_in -> iThreshold         - threshold latched on start
//             grid_req / grid_valid              - line-buffer window handshake
//             edgedetect_enable / mean_average_enable / isEdge - detector
//             result_valid / result_ready / result_edge / cur_x / cur_y
//             busy, done (1-cycle pulse), err (sticky detector timeout)
//  Revision : 1.0 - initial release
// ============================================================================
module edge_scan_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int TMO   = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [7:0]               threshold_in,
    input  logic                     grid_valid,
    input  logic                     mean_average_enable,
    input  logic                     isEdge,
    input  logic                     result_ready,
    output logic [7:0]               iThreshold,
    output logic                     edgedetect_enable,
    output logic                     grid_req,
    output logic [$clog2(IMG_W)-1:0] cur_x,
    output logic [$clog2(IMG_H)-1:0] cur_y,
    output logic                     result_valid,
    output logic                     result_edge,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(TMO + 1);

    localparam logic [XW-1:0] c_X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] c_Y_LAST = YW'(IMG_H - 1);
    localparam logic [CW-1:0] c_TMO    = CW'(TMO);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_NEXT = 3'd1;
    localparam logic [2:0] S_GRID = 3'd2;
    localparam logic [2:0] S_FIRE = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [7:0]    r_thr;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_wcnt;
    logic          r_edge;
    logic          r_err;

    logic          w_border;
    logic          w_last;
    logic [CW-1:0] w_wcnt_inc;
    logic          w_timeout;

    assign w_border   = (r_x == '0) || (r_x == c_X_LAST) ||
                        (r_y == '0) || (r_y == c_Y_LAST);
    assign w_last     = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
    assign w_wcnt_inc = r_wcnt + 1'b1;
    // The counter value after this WAIT cycle; reaching TMO ends the wait
    // unless the strobe arrives in the same cycle (strobe wins).
    assign w_timeout  = (w_wcnt_inc >= c_TMO);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; abort overrides every transition, including start.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_state_nxt = S_NEXT;
                S_NEXT: w_state_nxt = w_border ? S_OUT : S_GRID;
                S_GRID: if (grid_valid) w_state_nxt = S_FIRE;
                S_FIRE: w_state_nxt = S_WAIT;
                S_WAIT: if (mean_average_enable || w_timeout) w_state_nxt = S_OUT;
                S_OUT:  if (result_ready) w_state_nxt = w_last ? S_DONE : S_NEXT;
                S_DONE: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode: only registered state and registered coordinates.
    // ------------------------------------------------------------------
    always_comb begin
        busy              = (r_state != S_IDLE);
        grid_req          = (r_state == S_NEXT) && !w_border;
        edgedetect_enable = (r_state == S_FIRE);
        result_valid      = (r_state == S_OUT);
        done              = (r_state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath registers. An abort freezes everything, so err survives it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_thr  <= 8'd0;
            r_x    <= '0;
            r_y    <= '0;
            r_wcnt <= '0;
            r_edge <= 1'b0;
            r_err  <= 1'b0;
        end else if (!abort) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_thr <= threshold_in;
                        r_x   <= '0;
                        r_y   <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_NEXT: begin
                    if (w_border) r_edge <= 1'b0;
                end
                S_FIRE: begin
                    r_wcnt <= '0;
                end
                S_WAIT: begin
                    r_wcnt <= w_wcnt_inc;
                    if (mean_average_enable) begin
                        r_edge <= isEdge;
                    end else if (w_timeout) begin
                        r_err  <= 1'b1;
                        r_edge <= 1'b0;
                    end
                end
                S_OUT: begin
                    // The final pixel leaves the coordinates parked on it.
                    if (result_ready && !w_last) begin
                        if (r_x == c_X_LAST) begin
                            r_x <= '0;
                            r_y <= r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign iThreshold  = r_thr;
    assign cur_x       = r_x;
    assign cur_y       = r_y;
    assign result_edge = r_edge;
    assign err         = r_err;

endmodule
`default_nettype wire
